// File: rtl/apb_pkg.sv
// APB shared definitions: bus widths, requester FSM states and
// response flag bit positions, used by the initiator and the APB targets.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Requester transfer phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Bit positions inside the packed response flag vector.
    localparam int RSP_ERR_BIT = 0;
    localparam int RSP_TO_BIT  = 1;
    localparam int RSP_FLAGS_W = 2;

endpackage

// File: rtl/apb_wait_timer.sv
// Bounded wait counter for the APB ACCESS phase.
// Ports: CLK, RESETn (sync, active-low), clr, en, expired.
module apb_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    // With LIMIT = 0 the counter only saturates; expired never fires.
    localparam logic [W-1:0] LAST =
        (LIMIT == 0) ? {W{1'b1}} : W'(LIMIT - 1);

    logic [W-1:0] cnt;
    logic         at_last;

    assign at_last = (cnt == LAST);
    assign expired = (LIMIT != 0) && en && at_last;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_initiator.sv
// APB3 requester: one command stream transfer -> one APB transfer -> one response.
// Ports: CLK, RESETn; CMD_* command stream; RSP_* response stream; P* APB bus.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t             state;
    logic [RSP_FLAGS_W-1:0] rsp_flags;
    logic                   cmd_hs;
    logic                   tmr_en;
    logic                   tmr_expired;

    assign cmd_hs      = (state == IDLE) && CMD_VALID && CMD_READY;
    assign tmr_en      = (state == ACCESS) && !PREADY;
    assign RSP_ERR     = rsp_flags[RSP_ERR_BIT];
    assign RSP_TIMEOUT = rsp_flags[RSP_TO_BIT];

    apb_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .clr     (cmd_hs),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // PADDR/PWRITE/PWDATA double as the captured command registers.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= IDLE;
            CMD_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            rsp_flags <= '0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        CMD_READY <= 1'b0;
                        PSEL      <= 1'b1;
                        PADDR     <= CMD_ADDR;
                        PWRITE    <= CMD_WRITE;
                        PWDATA    <= CMD_WRITE ? CMD_WDATA : '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY on the last allowed cycle beats the timeout.
                    if (PREADY || tmr_expired) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PADDR     <= '0;
                        PWRITE    <= 1'b0;
                        PWDATA    <= '0;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                        if (PREADY) begin
                            rsp_flags[RSP_ERR_BIT] <= PSLVERR;
                            rsp_flags[RSP_TO_BIT]  <= 1'b0;
                            RSP_RDATA <= (!PWRITE && !PSLVERR)
                                         ? PRDATA : '0;
                        end else begin
                            rsp_flags[RSP_ERR_BIT] <= 1'b1;
                            rsp_flags[RSP_TO_BIT]  <= 1'b1;
                            RSP_RDATA <= '0;
                        end
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        RSP_RDATA <= '0;
                        rsp_flags <= '0;
                        CMD_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator against a small APB target model
// with programmable wait states, PSLVERR and a stuck-PREADY mode.
module tb_apb_initiator;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = '0;
    logic [31:0] CMD_WDATA = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        RSP_TIMEOUT;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    int total = 0;
    int bad = 0;

    int          tgt_waits = 0;
    logic        tgt_err = 1'b0;
    logic        tgt_stuck = 1'b0;
    logic [31:0] tgt_rdata = '0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    apb_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_ERR     (RSP_ERR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .PRDATA      (PRDATA)
    );

    always #5 CLK = ~CLK;

    // Target model: ready after tgt_waits ACCESS wait cycles.
    assign PREADY  = PSEL && PENABLE && !tgt_stuck
                     && (acc_cnt == tgt_waits);
    assign PSLVERR = PREADY && tgt_err;
    assign PRDATA  = PREADY ? tgt_rdata : 32'hBAD0BAD0;

    always_ff @(posedge CLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= PADDR;
            wr_data <= PWDATA;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command and step until RSP_VALID (bounded).
    // Cycle 1 is the first cycle after the command handshake edge.
    task automatic run_xfer(input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int maxc,
                            output int rsp_cyc, output int pen_cyc);
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        rsp_cyc = -1;
        pen_cyc = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge CLK);
            if (c == 1) CMD_VALID = 1'b0;
            if (PENABLE) pen_cyc++;
            if (RSP_VALID) begin
                rsp_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL rst_cmd_ready act=%b exp=1", CMD_READY);
        end
        total++;
        if ({PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT}
            !== 6'b0) begin
            bad++;
            $display("FAIL rst_flags act=%b%b%b%b%b%b exp=000000",
                     PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR,
                     RSP_TIMEOUT);
        end
        total++;
        if ({PADDR, PWDATA, RSP_RDATA} !== 96'h0) begin
            bad++;
            $display("FAIL rst_buses act=%h/%h/%h exp=0",
                     PADDR, PWDATA, RSP_RDATA);
        end
        RESETn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_cnt;
        tgt_waits = 0;
        tgt_err = 1'b0;
        tgt_stuck = 1'b0;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 32'h4;
        CMD_WDATA = 32'h1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        total++;
        if ({PSEL, PENABLE, PWRITE, CMD_READY} !== 4'b1010) begin
            bad++;
            $display("FAIL wr_setup act=%b%b%b%b exp=1010",
                     PSEL, PENABLE, PWRITE, CMD_READY);
        end
        total++;
        if (PADDR !== 32'h4 || PWDATA !== 32'h1) begin
            bad++;
            $display("FAIL wr_setup_bus act=%h/%h exp=4/1",
                     PADDR, PWDATA);
        end
        @(negedge CLK);
        total++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PWDATA !== 32'h1) begin
            bad++;
            $display("FAIL wr_access act=%b%b%b/%h exp=111/1",
                     PSEL, PENABLE, PWRITE, PWDATA);
        end
        @(negedge CLK);
        total++;
        if ({RSP_VALID, RSP_ERR, RSP_TIMEOUT, PSEL} !== 4'b1000
            || RSP_RDATA !== 32'h0) begin
            bad++;
            $display("FAIL wr_resp act=%b%b%b%b/%h exp=1000/0",
                     RSP_VALID, RSP_ERR, RSP_TIMEOUT, PSEL, RSP_RDATA);
        end
        total++;
        if (wr_cnt !== w0 + 1 || wr_addr !== 32'h4
            || wr_data !== 32'h1) begin
            bad++;
            $display("FAIL wr_target act=%0d/%h/%h exp=%0d/4/1",
                     wr_cnt, wr_addr, wr_data, w0 + 1);
        end
        @(negedge CLK);
        total++;
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL wr_idle act=%b%b exp=01",
                     RSP_VALID, CMD_READY);
        end
    endtask

    task automatic test_read_wait();
        int rc, pc;
        tgt_waits = 3;
        tgt_rdata = 32'h5A5A5A5A;
        run_xfer(1'b0, 32'h0, 32'hFFFFFFFF, 12, rc, pc);
        total++;
        if (rc !== 6 || pc !== 4) begin
            bad++;
            $display("FAIL rd_wait_timing act=rsp%0d/pen%0d exp=6/4",
                     rc, pc);
        end
        total++;
        if (RSP_RDATA !== 32'h5A5A5A5A || RSP_ERR !== 1'b0) begin
            bad++;
            $display("FAIL rd_wait_data act=%h/%b exp=5a5a5a5a/0",
                     RSP_RDATA, RSP_ERR);
        end
        @(negedge CLK);
    endtask

    task automatic test_read_stable();
        int stable_bad = 0;
        tgt_waits = 2;
        tgt_rdata = 32'h00C0FFEE;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'h0000_0123;
        CMD_WDATA = 32'hFFFFFFFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0;
            if (PADDR !== 32'h123 || PWDATA !== 32'h0
                || PWRITE !== 1'b0 || PSEL !== 1'b1)
                stable_bad++;
        end
        total++;
        if (stable_bad !== 0) begin
            bad++;
            $display("FAIL rd_bus_stable act=%0d exp=0", stable_bad);
        end
        @(negedge CLK);
        total++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h00C0FFEE) begin
            bad++;
            $display("FAIL rd_unaligned act=%b/%h exp=1/00c0ffee",
                     RSP_VALID, RSP_RDATA);
        end
        @(negedge CLK);
    endtask

    task automatic test_slverr();
        int rc, pc;
        tgt_waits = 1;
        tgt_err = 1'b1;
        tgt_rdata = 32'hDEADBEEF;
        run_xfer(1'b0, 32'h10, 32'h0, 12, rc, pc);
        total++;
        if (rc !== 4 || RSP_ERR !== 1'b1 || RSP_TIMEOUT !== 1'b0
            || RSP_RDATA !== 32'h0) begin
            bad++;
            $display("FAIL slverr act=%0d/%b%b/%h exp=4/10/0",
                     rc, RSP_ERR, RSP_TIMEOUT, RSP_RDATA);
        end
        tgt_err = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int rc, pc;
        tgt_stuck = 1'b1;
        run_xfer(1'b0, 32'h20, 32'h0, 30, rc, pc);
        total++;
        if (rc !== 10 || pc !== 8) begin
            bad++;
            $display("FAIL to_timing act=rsp%0d/pen%0d exp=10/8",
                     rc, pc);
        end
        total++;
        if ({RSP_ERR, RSP_TIMEOUT, PSEL, PENABLE} !== 4'b1100
            || RSP_RDATA !== 32'h0) begin
            bad++;
            $display("FAIL to_flags act=%b%b%b%b/%h exp=1100/0",
                     RSP_ERR, RSP_TIMEOUT, PSEL, PENABLE, RSP_RDATA);
        end
        @(negedge CLK);
        tgt_stuck = 1'b0;
        tgt_waits = 7;
        tgt_rdata = 32'h12345678;
        run_xfer(1'b0, 32'h24, 32'h0, 30, rc, pc);
        total++;
        if (rc !== 10 || pc !== 8 || {RSP_ERR, RSP_TIMEOUT} !== 2'b00
            || RSP_RDATA !== 32'h12345678) begin
            bad++;
            $display("FAIL to_last_ready act=%0d/%0d/%b%b/%h exp=10/8/00/12345678",
                     rc, pc, RSP_ERR, RSP_TIMEOUT, RSP_RDATA);
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        int rc, pc, hold_bad, w0;
        hold_bad = 0;
        tgt_waits = 0;
        RSP_READY = 1'b0;
        w0 = wr_cnt;
        run_xfer(1'b1, 32'h8, 32'hAA, 12, rc, pc);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'hC;
        tgt_rdata = 32'h13572468;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0
                || RSP_RDATA !== 32'h0 || CMD_READY !== 1'b0
                || PSEL !== 1'b0)
                hold_bad++;
        end
        total++;
        if (rc !== 3 || hold_bad !== 0) begin
            bad++;
            $display("FAIL bp_hold act=rsp%0d/bad%0d exp=3/0",
                     rc, hold_bad);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        total++;
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL bp_release act=%b%b exp=01",
                     RSP_VALID, CMD_READY);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        total++;
        if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'hC) begin
            bad++;
            $display("FAIL bp_second_setup act=%b%b/%h exp=10/c",
                     PSEL, PENABLE, PADDR);
        end
        repeat (2) @(negedge CLK);
        total++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h13572468) begin
            bad++;
            $display("FAIL bp_second_rsp act=%b/%h exp=1/13572468",
                     RSP_VALID, RSP_RDATA);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (PSEL !== 1'b0 || CMD_READY !== 1'b1 || wr_cnt !== w0 + 1
            || wr_data !== 32'hAA) begin
            bad++;
            $display("FAIL bp_no_dup act=%b%b/%0d/%h exp=01/%0d/aa",
                     PSEL, CMD_READY, wr_cnt, wr_data, w0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int setups = 0;
        int first = -1;
        int last = -1;
        tgt_waits = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 32'h30;
        CMD_WDATA = 32'h55;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 9) CMD_VALID = 1'b0;
            if (PSEL && !PENABLE) begin
                setups++;
                if (first < 0) first = c;
                last = c;
            end
        end
        total++;
        if (setups !== 3 || first !== 1 || last !== 9) begin
            bad++;
            $display("FAIL b2b_rate act=%0d@%0d..%0d exp=3@1..9",
                     setups, first, last);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_mid_reset();
        int rc, pc;
        tgt_stuck = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'h40;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        total++;
        if ({PSEL, PENABLE, RSP_VALID, CMD_READY} !== 4'b0001) begin
            bad++;
            $display("FAIL mid_reset act=%b%b%b%b exp=0001",
                     PSEL, PENABLE, RSP_VALID, CMD_READY);
        end
        RESETn = 1'b1;
        tgt_stuck = 1'b0;
        tgt_waits = 0;
        tgt_rdata = 32'h0F0F0F0F;
        run_xfer(1'b0, 32'h44, 32'h0, 12, rc, pc);
        total++;
        if (rc !== 3 || RSP_RDATA !== 32'h0F0F0F0F
            || {RSP_ERR, RSP_TIMEOUT} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_rd act=%0d/%h/%b%b exp=3/0f0f0f0f/00",
                     rc, RSP_RDATA, RSP_ERR, RSP_TIMEOUT);
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_read_stable();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
